multi_oneshot: RTL and testbench
================================

# multi_oneshot

Parametrised, multi-channel, programmable-length one-shot stretcher for the 250 MHz trigger path. Each channel turns a trigger (any cycle with `trig_i` high and unmasked) into a clean `scal_o` gate of run-time-selectable length, with selectable retrigger behaviour and a programmable dead time, so the scalers count discrete events rather than raw trigger-high cycles. It generalises the fixed 16-cycle single-channel stretcher to N channels with per-pulse start strobes and a global busy flag.

## Interface
Parameters:
- `NCH`, 8, number of independent channels
- `CNTW`, 8, width of length/holdoff counters (max length/holdoff = 2^CNTW-1 cycles)

Ports:
- `clk250_i`  in  1  250 MHz system clock; all logic on rising edge
- `rst_n_i`  in  1  synchronous, active-low reset
- `trig_i`  in  NCH  per-channel trigger, level, synchronous to `clk250_i`
- `mask_i`  in  NCH  per-channel enable; 0 = trigger ignored
- `len_i`  in  CNTW  gate length in cycles; 0 treated as 1
- `holdoff_i`  in  CNTW  dead cycles after gate ends; 0 = none
- `retrig_i`  in  1  1 = trigger during gate restarts length; 0 = ignored
- `scal_o`  out  NCH  stretched gate per channel, registered
- `start_o`  out  NCH  one-cycle strobe on first cycle of each new gate (not on retrigger extension)
- `busy_o`  out  1  registered OR of all channels not in IDLE

## Operation
- Per channel FSM: IDLE, ACTIVE, HOLDOFF. Trigger event `ev = trig_i[c] & mask_i[c]`.
- IDLE: ev -> ACTIVE, load cnt = max(len_i,1)-1, assert `start_o[c]` next cycle.
- ACTIVE: `scal_o[c]`=1.
  - ev & retrig_i -> reload cnt = max(len_i,1)-1, stay ACTIVE (also on the final ACTIVE cycle).
  - else cnt==0 -> HOLDOFF with hcnt = holdoff_i-1 if holdoff_i!=0, else IDLE.
  - else cnt decrements.
- HOLDOFF: all triggers ignored, both modes; hcnt==0 -> IDLE, else decrement.
- `len_i`/`holdoff_i` sampled only at load time (start, reload, HOLDOFF entry); changes mid-gate do not alter the running count.
- Deasserting `mask_i[c]` mid-gate does not truncate; it only blocks new events.
- `retrig_i` evaluated each cycle; switching it mid-gate affects subsequent triggers only.
- Channels fully independent; no cross-channel interaction except `busy_o`.
- Counter arithmetic unsigned, CNTW bits, no wrap: load values never exceed 2^CNTW-1.

## Timing
- Reset (`rst_n_i`=0 at an edge): all channels IDLE, counters 0; `scal_o`, `start_o`, `busy_o` = 0 from next cycle, including mid-gate/mid-holdoff. Triggers during reset ignored.
- Latency: ev sampled at edge t -> `scal_o`=1 and `start_o`=1 from cycle t+1.
- Single-cycle ev, len L: `scal_o` high exactly L cycles (t+1..t+L); retrig mode: gate ends L cycles after last ev cycle.
- Holdoff H: IDLE re-entered H cycles after gate drops; earliest new gate starts H+1 cycles after last high cycle (H=0: one-cycle low gap minimum between distinct gates).
- Continuous ev, retrig=1: `scal_o` held high indefinitely, single `start_o`.
- `busy_o` registered from next-state, so aligned with `scal_o`/HOLDOFF occupancy.

## Structure
- Shared package/include `oneshot_pkg`: state encodings (IDLE=2'd0, ACTIVE=2'd1, HOLDOFF=2'd2), default CNTW.
- Sub-module `oneshot_chan` (one FSM + counter, CNTW param); top instantiates NCH copies via generate and forms `busy_o`.

## Test plan
- Reset, len=16, retrig=1, one-cycle trig on ch0 at t -> `scal_o[0]` high t+1..t+16, `start_o[0]` only at t+1, other channels 0.
- len=4, retrig=1, ev at t and t+3 -> gate t+1..t+7, single start; retrig=0 same stimulus -> gate t+1..t+4.
- len=3, holdoff=5, retrig=0, trig held high -> gates of 3 cycles separated by 6 low cycles, one `start_o` per gate.
- len=0 -> 1-cycle gate; len=255 (CNTW=8) -> 255-cycle gate; change `len_i` mid-gate -> no effect on current gate.
- `mask_i[2]`=0 with trig -> no gate; mask cleared mid-gate -> gate completes full length.
- `rst_n_i` low mid-ACTIVE and mid-HOLDOFF on several channels -> all outputs 0 next cycle; trigger after release starts normally with 1-cycle latency.

Source files
------------

// File: rtl/oneshot_pkg.sv
// -----------------------------------------------------------------------------
// oneshot_pkg
//
// Shared definitions for the multi-channel one-shot stretcher:
//   - chan_state_t : per-channel FSM state encoding
//   - DEF_NCH      : default number of channels
//   - DEF_CNTW     : default width of the length/holdoff counter
//
// No ports; imported by oneshot_chan and multi_oneshot.
// -----------------------------------------------------------------------------
package oneshot_pkg;

    // Default channel count for the trigger path.
    localparam int DEF_NCH = 8;

    // Default counter width; the longest gate or holdoff is 2^CNTW-1 cycles.
    localparam int DEF_CNTW = 8;

    // Per-channel FSM states. The encodings are fixed so that other blocks
    // and debug taps can decode a raw state value.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } chan_state_t;

endpackage : oneshot_pkg

// File: rtl/oneshot_chan.sv
// -----------------------------------------------------------------------------
// oneshot_chan
//
// One channel of the programmable one-shot stretcher. A trigger event
// (trig_i & mask_i) seen in IDLE opens a gate of len_i cycles (0 behaves as 1).
// The gate is followed by holdoff_i dead cycles in which every trigger is
// ignored. With retrig_i high, an event during the gate restarts the length
// count, so the gate ends len_i cycles after the last event.
//
// Ports:
//   clk250_i     in   system clock, rising edge
//   rst_n_i      in   synchronous active-low reset
//   trig_i       in   trigger level
//   mask_i       in   channel enable (0 blocks new events only)
//   len_i        in   gate length, sampled on start/reload
//   holdoff_i    in   dead time after the gate, sampled on gate end
//   retrig_i     in   1 = events during the gate extend it
//   scal_o       out  registered gate
//   start_o      out  registered one-cycle strobe on the first gate cycle
//   busy_next_o  out  combinational "next state is not IDLE", for the
//                     top-level busy register
// -----------------------------------------------------------------------------
module oneshot_chan
    import oneshot_pkg::*;
#(
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk250_i,
    input  logic            rst_n_i,
    input  logic            trig_i,
    input  logic            mask_i,
    input  logic [CNTW-1:0] len_i,
    input  logic [CNTW-1:0] holdoff_i,
    input  logic            retrig_i,
    output logic            scal_o,
    output logic            start_o,
    output logic            busy_next_o
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    chan_state_t     state;
    chan_state_t     state_next;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_next;
    logic            start_next;
    logic            ev;
    logic [CNTW-1:0] len_load;
    logic [CNTW-1:0] hold_load;

    assign ev = trig_i & mask_i;

    // The counter holds "cycles remaining after this one", so a length of L
    // loads L-1. A zero length is promoted to a single-cycle gate.
    assign len_load = (len_i == '0) ? '0 : (len_i - CNT_ONE);

    // Only used when holdoff_i is non-zero, so the subtraction never wraps.
    assign hold_load = holdoff_i - CNT_ONE;

    // Next-state and counter logic. A retrigger is checked before the
    // end-of-gate test so that an event on the final gate cycle still
    // extends the gate instead of letting it drop.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ev) begin
                    state_next = ST_ACTIVE;
                    cnt_next   = len_load;
                    start_next = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (ev && retrig_i) begin
                    cnt_next = len_load;
                end else if (cnt == '0) begin
                    if (holdoff_i != '0) begin
                        state_next = ST_HOLDOFF;
                        cnt_next   = hold_load;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            ST_HOLDOFF: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so that scal_o and start_o
    // appear in the same cycle the FSM enters ACTIVE.
    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            scal_o  <= 1'b0;
            start_o <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            scal_o  <= (state_next == ST_ACTIVE);
            start_o <= start_next;
        end
    end

    assign busy_next_o = (state_next != ST_IDLE);

endmodule : oneshot_chan

// File: rtl/multi_oneshot.sv
// -----------------------------------------------------------------------------
// multi_oneshot
//
// NCH independent one-shot stretchers for the 250 MHz trigger path, sharing
// the length, holdoff and retrigger controls, plus a global busy flag.
//
// Ports:
//   clk250_i   in   system clock, rising edge
//   rst_n_i    in   synchronous active-low reset
//   trig_i     in   [NCH]   per-channel trigger level
//   mask_i     in   [NCH]   per-channel enable
//   len_i      in   [CNTW]  gate length in cycles (0 = 1)
//   holdoff_i  in   [CNTW]  dead cycles after each gate (0 = none)
//   retrig_i   in   retrigger-extends-gate select
//   scal_o     out  [NCH]   stretched gates
//   start_o    out  [NCH]   one-cycle strobe at the start of each new gate
//   busy_o     out  registered OR of "channel not IDLE"
// -----------------------------------------------------------------------------
module multi_oneshot
    import oneshot_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk250_i,
    input  logic            rst_n_i,
    input  logic [NCH-1:0]  trig_i,
    input  logic [NCH-1:0]  mask_i,
    input  logic [CNTW-1:0] len_i,
    input  logic [CNTW-1:0] holdoff_i,
    input  logic            retrig_i,
    output logic [NCH-1:0]  scal_o,
    output logic [NCH-1:0]  start_o,
    output logic            busy_o
);

    logic [NCH-1:0] busy_next;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        oneshot_chan #(
            .CNTW(CNTW)
        ) u_chan (
            .clk250_i    (clk250_i),
            .rst_n_i     (rst_n_i),
            .trig_i      (trig_i[c]),
            .mask_i      (mask_i[c]),
            .len_i       (len_i),
            .holdoff_i   (holdoff_i),
            .retrig_i    (retrig_i),
            .scal_o      (scal_o[c]),
            .start_o     (start_o[c]),
            .busy_next_o (busy_next[c])
        );
    end

    // Busy is registered from the channels' next states, so it lines up
    // cycle-for-cycle with the registered gates and holdoff occupancy.
    always_ff @(posedge clk250_i) begin
        if (!rst_n_i) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= |busy_next;
        end
    end

endmodule : multi_oneshot

// File: tb/tb_multi_oneshot.sv
// -----------------------------------------------------------------------------
// tb_multi_oneshot
//
// Self-checking bench for multi_oneshot. A timestamp-based reference model
// (gate start/end cycle and the first cycle a channel may accept a new event)
// predicts every output on every cycle. Directed scenarios are followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_multi_oneshot;

    localparam int NCH  = 8;
    localparam int CNTW = 8;

    logic            clk250_i = 1'b0;
    logic            rst_n_i;
    logic [NCH-1:0]  trig_i;
    logic [NCH-1:0]  mask_i;
    logic [CNTW-1:0] len_i;
    logic [CNTW-1:0] holdoff_i;
    logic            retrig_i;
    logic [NCH-1:0]  scal_o;
    logic [NCH-1:0]  start_o;
    logic            busy_o;

    multi_oneshot #(
        .NCH (NCH),
        .CNTW(CNTW)
    ) dut (
        .clk250_i  (clk250_i),
        .rst_n_i   (rst_n_i),
        .trig_i    (trig_i),
        .mask_i    (mask_i),
        .len_i     (len_i),
        .holdoff_i (holdoff_i),
        .retrig_i  (retrig_i),
        .scal_o    (scal_o),
        .start_o   (start_o),
        .busy_o    (busy_o)
    );

    always #2 clk250_i = ~clk250_i;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: absolute cycle numbers per channel.
    int gate_start [NCH];
    int gate_end   [NCH];
    int ready_at   [NCH];

    // Observed pulse statistics for the directed width checks.
    int high_cnt  [NCH];
    int start_cnt [NCH];

    logic [NCH-1:0] exp_scal;
    logic [NCH-1:0] exp_start;
    logic           exp_busy;

    task automatic check_output(input string tag, input logic [NCH-1:0] obs,
                                input logic [NCH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advances the model across the edge numbered cyc, using the inputs
    // sampled at that edge, and produces the outputs expected during cycle cyc.
    function automatic void model_edge();
        int   cur;
        int   len_eff;
        logic ev;
        logic active;
        logic idle;
        cur      = cyc - 1;
        len_eff  = (len_i == '0) ? 1 : int'(len_i);
        exp_busy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n_i) begin
                gate_start[c] = -1000;
                gate_end[c]   = -1000;
                ready_at[c]   = 0;
            end else begin
                ev     = trig_i[c] & mask_i[c];
                active = (cur >= gate_start[c]) && (cur <= gate_end[c]);
                idle   = !active && (cur >= ready_at[c]);
                if (idle && ev) begin
                    gate_start[c] = cyc;
                    gate_end[c]   = cyc + len_eff - 1;
                end else if (active && ev && retrig_i) begin
                    gate_end[c] = cyc + len_eff - 1;
                end else if (active && (cur == gate_end[c])) begin
                    ready_at[c] = cyc + int'(holdoff_i);
                end
            end
            exp_scal[c]  = (cyc >= gate_start[c]) && (cyc <= gate_end[c]);
            exp_start[c] = (gate_start[c] == cyc);
            if (exp_scal[c] || (cyc < ready_at[c])) exp_busy = 1'b1;
        end
    endfunction

    task automatic run_cycle();
        @(posedge clk250_i);
        cyc++;
        model_edge();
        #1;
        check_output("scal", scal_o, exp_scal);
        check_output("start", start_o, exp_start);
        check_output("busy", NCH'(busy_o), NCH'(exp_busy));
        for (int c = 0; c < NCH; c++) begin
            high_cnt[c]  += int'(scal_o[c]);
            start_cnt[c] += int'(start_o[c]);
        end
    endtask

    task automatic apply_stimulus(input logic rst_n, input logic [NCH-1:0] trig,
                                  input logic [NCH-1:0] mask, input int len,
                                  input int hold, input logic retrig, input int n);
        rst_n_i   = rst_n;
        trig_i    = trig;
        mask_i    = mask;
        len_i     = CNTW'(len);
        holdoff_i = CNTW'(hold);
        retrig_i  = retrig;
        repeat (n) run_cycle();
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) begin
            high_cnt[c]  = 0;
            start_cnt[c] = 0;
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            gate_start[c] = -1000;
            gate_end[c]   = -1000;
            ready_at[c]   = 0;
        end
        clear_counts();
        rst_n_i = 1'b0; trig_i = '0; mask_i = '1;
        len_i = '0; holdoff_i = '0; retrig_i = 1'b0;

        $display("[TB] reset with triggers asserted");
        apply_stimulus(1'b0, '1, '1, 16, 0, 1'b1, 3);

        $display("[TB] len=16 single trigger on ch0");
        clear_counts();
        apply_stimulus(1'b1, '0, '1, 16, 0, 1'b1, 1);
        apply_stimulus(1'b1, 8'h01, '1, 16, 0, 1'b1, 1);
        apply_stimulus(1'b1, '0, '1, 16, 0, 1'b1, 20);
        check_count("len16_width", high_cnt[0], 16);
        check_count("len16_starts", start_cnt[0], 1);
        check_count("len16_other_ch", high_cnt[1], 0);

        $display("[TB] len=4 retrigger on / off");
        clear_counts();
        apply_stimulus(1'b1, 8'h01, '1, 4, 0, 1'b1, 1);
        apply_stimulus(1'b1, '0, '1, 4, 0, 1'b1, 2);
        apply_stimulus(1'b1, 8'h01, '1, 4, 0, 1'b1, 1);
        apply_stimulus(1'b1, '0, '1, 4, 0, 1'b1, 10);
        check_count("retrig_width", high_cnt[0], 7);
        check_count("retrig_starts", start_cnt[0], 1);
        clear_counts();
        apply_stimulus(1'b1, 8'h01, '1, 4, 0, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 4, 0, 1'b0, 2);
        apply_stimulus(1'b1, 8'h01, '1, 4, 0, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 4, 0, 1'b0, 10);
        check_count("noretrig_width", high_cnt[0], 4);

        $display("[TB] len=3 holdoff=5 held trigger on ch1");
        clear_counts();
        apply_stimulus(1'b1, 8'h02, '1, 3, 5, 1'b0, 30);
        apply_stimulus(1'b1, '0, '1, 3, 5, 1'b0, 10);
        check_count("holdoff_high", high_cnt[1], 12);
        check_count("holdoff_starts", start_cnt[1], 4);

        $display("[TB] len=0 and len=255 with mid-gate length change");
        clear_counts();
        apply_stimulus(1'b1, 8'h08, '1, 0, 0, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 0, 0, 1'b0, 4);
        check_count("len0_width", high_cnt[3], 1);
        clear_counts();
        apply_stimulus(1'b1, 8'h08, '1, 255, 0, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 5, 0, 1'b0, 270);
        check_count("len255_width", high_cnt[3], 255);

        $display("[TB] masking");
        clear_counts();
        apply_stimulus(1'b1, 8'h04, 8'hFB, 10, 0, 1'b0, 5);
        check_count("masked_width", high_cnt[2], 0);
        apply_stimulus(1'b1, 8'h04, '1, 10, 0, 1'b1, 1);
        apply_stimulus(1'b1, 8'h04, 8'hFB, 10, 0, 1'b1, 15);
        check_count("mask_cleared_width", high_cnt[2], 10);

        $display("[TB] reset mid-gate and mid-holdoff");
        apply_stimulus(1'b1, 8'h20, '1, 4, 20, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 4, 20, 1'b0, 6);
        apply_stimulus(1'b1, 8'h10, '1, 30, 20, 1'b0, 1);
        apply_stimulus(1'b1, 8'h03, '1, 30, 20, 1'b0, 3);
        apply_stimulus(1'b0, '1, '1, 30, 20, 1'b0, 2);
        apply_stimulus(1'b1, 8'h10, '1, 6, 2, 1'b0, 1);
        apply_stimulus(1'b1, '0, '1, 6, 2, 1'b0, 12);

        $display("[TB] randomized run");
        begin
            logic            r_retrig;
            logic [NCH-1:0]  r_trig;
            logic [NCH-1:0]  r_mask;
            logic            r_rst_n;
            r_retrig = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ((i % 25) == 0) r_retrig = 1'($urandom_range(0, 1));
                for (int c = 0; c < NCH; c++) begin
                    r_trig[c] = ($urandom_range(0, 5) == 0);
                    r_mask[c] = ($urandom_range(0, 7) != 0);
                end
                r_rst_n = ($urandom_range(0, 199) != 0);
                apply_stimulus(r_rst_n, r_trig, r_mask, int'($urandom_range(0, 12)),
                               int'($urandom_range(0, 6)), r_retrig, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_multi_oneshot
